// File: rtl/input_debouncer.sv
// input_debouncer
//   Debounces an asynchronous switch/button level. raw_in is brought into the
//   clk domain through a two-flop synchronizer. A new level is accepted only
//   after the synchronized input has held it on STABLE_CYCLES+1 consecutive
//   rising edges. After acceptance, clean_out changes and rise or fall pulses
//   for one cycle.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   S_LOW   (00) | accepted level 0, waiting for sync_in=1
//   S_WAIT_H(01) | sync_in went 1, counting stable samples toward accept
//   S_HIGH  (10) | accepted level 1, waiting for sync_in=0
//   S_WAIT_L(11) | sync_in went 0, counting stable samples toward accept
//
// Ports
//   clk        : single clock, rising-edge
//   reset      : asynchronous, active-low reset
//   raw_in     : raw switch level, asynchronous to clk
//   clean_out  : debounced level (1 in S_HIGH / S_WAIT_LOW)
//   rise       : one-cycle pulse on clean_out 0->1
//   fall       : one-cycle pulse on clean_out 1->0
//   state      : current FSM state (debug)
//   stable_cnt : current stability counter value
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 raw_in,
  output logic                 clean_out,
  output logic                 rise,
  output logic                 fall,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stable_cnt
);

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b10,
    S_WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t st;
  logic   sync_meta;
  logic   sync_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta  <= 1'b0;
      sync_in    <= 1'b0;
      st         <= S_LOW;
      stable_cnt <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      sync_meta <= raw_in;
      sync_in   <= sync_meta;
      rise      <= 1'b0;
      fall      <= 1'b0;
      case (st)
        S_LOW: begin
          stable_cnt <= '0;
          if (sync_in) st <= S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          if (!sync_in) begin
            st         <= S_LOW;
            stable_cnt <= '0;
          end else if (stable_cnt == CNT_LAST) begin
            st         <= S_HIGH;
            stable_cnt <= '0;
            rise       <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          stable_cnt <= '0;
          if (!sync_in) st <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (sync_in) begin
            st         <= S_HIGH;
            stable_cnt <= '0;
          end else if (stable_cnt == CNT_LAST) begin
            st         <= S_LOW;
            stable_cnt <= '0;
            fall       <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        default: begin
          st         <= S_LOW;
          stable_cnt <= '0;
        end
      endcase
    end
  end

  // Accepted level is the MSB of the state encoding; purely registered.
  assign clean_out = st[1];
  assign state     = st;

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  logic       clk;
  logic       reset;
  logic       raw0, raw1;
  logic       clean0, rise0, fall0;
  logic [1:0] state0;
  logic [2:0] cnt0;
  logic       clean1, rise1, fall1;
  logic [1:0] state1;
  logic [0:0] cnt1;

  int checks   = 0;
  int failures = 0;

  input_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(3)) u0 (
    .clk(clk), .reset(reset), .raw_in(raw0),
    .clean_out(clean0), .rise(rise0), .fall(fall0),
    .state(state0), .stable_cnt(cnt0)
  );

  input_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .raw_in(raw1),
    .clean_out(clean1), .rise(rise1), .fall(fall1),
    .state(state1), .stable_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [1:0] st, input logic [2:0] c,
                      input logic cl, input logic r, input logic f);
    check({tag, ".state"}, 32'(state0), 32'(st));
    check({tag, ".cnt"},   32'(cnt0),   32'(c));
    check({tag, ".clean"}, 32'(clean0), 32'(cl));
    check({tag, ".rise"},  32'(rise0),  32'(r));
    check({tag, ".fall"},  32'(fall0),  32'(f));
  endtask

  task automatic chk1(input string tag, input logic [1:0] st, input logic [0:0] c,
                      input logic cl, input logic r, input logic f);
    check({tag, ".state"}, 32'(state1), 32'(st));
    check({tag, ".cnt"},   32'(cnt1),   32'(c));
    check({tag, ".clean"}, 32'(clean1), 32'(cl));
    check({tag, ".rise"},  32'(rise1),  32'(r));
    check({tag, ".fall"},  32'(fall1),  32'(f));
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step0(input string tag, input logic [1:0] st, input logic [2:0] c,
                       input logic cl, input logic r, input logic f);
    @(posedge clk); #1;
    chk0(tag, st, c, cl, r, f);
  endtask

  task automatic step1(input string tag, input logic [1:0] st, input logic [0:0] c,
                       input logic cl, input logic r, input logic f);
    @(posedge clk); #1;
    chk1(tag, st, c, cl, r, f);
  endtask

  initial begin
    reset = 1'b1;
    raw0  = 1'b0;
    raw1  = 1'b0;

    // Asynchronous reset before any clock edge
    #3 reset = 1'b0;
    #1;
    chk0("rst_async", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    chk1("rst_async1", 2'b00, 1'd0, 1'b0, 1'b0, 1'b0);
    raw0 = 1'b1;  // held under reset: must not advance anything
    step0("rst_held", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("rst_held2", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    raw0  = 1'b0;
    reset = 1'b1;
    step0("idle", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("idle2", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Accept rise: 7 edges of latency
    @(negedge clk); raw0 = 1'b1;
    step0("rise_e1", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("rise_e2", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("rise_e3", 2'b01, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("rise_e4", 2'b01, 3'd1, 1'b0, 1'b0, 1'b0);
    step0("rise_e5", 2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
    step0("rise_e6", 2'b01, 3'd3, 1'b0, 1'b0, 1'b0);
    step0("rise_e7", 2'b10, 3'd0, 1'b1, 1'b1, 1'b0);
    step0("rise_e8", 2'b10, 3'd0, 1'b1, 1'b0, 1'b0);

    // Accept fall from S_HIGH
    @(negedge clk); raw0 = 1'b0;
    step0("fall_e1", 2'b10, 3'd0, 1'b1, 1'b0, 1'b0);
    step0("fall_e2", 2'b10, 3'd0, 1'b1, 1'b0, 1'b0);
    step0("fall_e3", 2'b11, 3'd0, 1'b1, 1'b0, 1'b0);
    step0("fall_e4", 2'b11, 3'd1, 1'b1, 1'b0, 1'b0);
    step0("fall_e5", 2'b11, 3'd2, 1'b1, 1'b0, 1'b0);
    step0("fall_e6", 2'b11, 3'd3, 1'b1, 1'b0, 1'b0);
    step0("fall_e7", 2'b00, 3'd0, 1'b0, 1'b0, 1'b1);
    step0("fall_e8", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Glitch: high for exactly 4 cycles -> rejected
    @(negedge clk); raw0 = 1'b1;
    step0("g4_e1", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("g4_e2", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("g4_e3", 2'b01, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("g4_e4", 2'b01, 3'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); raw0 = 1'b0;
    step0("g4_e5", 2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
    step0("g4_e6", 2'b01, 3'd3, 1'b0, 1'b0, 1'b0);
    step0("g4_e7", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("g4_e8", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);

    // High for 5 cycles -> accepted
    @(negedge clk); raw0 = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk0("g5_e4", 2'b01, 3'd1, 1'b0, 1'b0, 1'b0);
    step0("g5_e5", 2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); raw0 = 1'b0;
    step0("g5_e6", 2'b01, 3'd3, 1'b0, 1'b0, 1'b0);
    step0("g5_e7", 2'b10, 3'd0, 1'b1, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    #1 chk0("g5_back_low", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-wait (state 01, cnt 2), asynchronously between edges
    @(negedge clk); raw0 = 1'b1;
    repeat (4) @(posedge clk);
    step0("rw_e5", 2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1 chk0("rw_async", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("rw_held", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk0("rw_e5b", 2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
    step0("rw_e6", 2'b01, 3'd3, 1'b0, 1'b0, 1'b0);
    step0("rw_e7", 2'b10, 3'd0, 1'b1, 1'b1, 1'b0);
    step0("rw_e8", 2'b10, 3'd0, 1'b1, 1'b0, 1'b0);

    // Reset in S_HIGH: no fall pulse generated
    #5 reset = 1'b0;
    #1 chk0("rh_async", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    raw0 = 1'b0;
    step0("rh_held", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    step0("rh_rel", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step0("rh_rel2", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);

    // STABLE_CYCLES=1 instance: accept after edge 4
    @(negedge clk); raw1 = 1'b1;
    step1("m_e1", 2'b00, 1'd0, 1'b0, 1'b0, 1'b0);
    step1("m_e2", 2'b00, 1'd0, 1'b0, 1'b0, 1'b0);
    step1("m_e3", 2'b01, 1'd0, 1'b0, 1'b0, 1'b0);
    step1("m_e4", 2'b10, 1'd0, 1'b1, 1'b1, 1'b0);
    step1("m_e5", 2'b10, 1'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); raw1 = 1'b0;
    step1("mf_e1", 2'b10, 1'd0, 1'b1, 1'b0, 1'b0);
    step1("mf_e2", 2'b10, 1'd0, 1'b1, 1'b0, 1'b0);
    step1("mf_e3", 2'b11, 1'd0, 1'b1, 1'b0, 1'b0);
    step1("mf_e4", 2'b00, 1'd0, 1'b0, 1'b0, 1'b1);
    step1("mf_e5", 2'b00, 1'd0, 1'b0, 1'b0, 1'b0);

    // One-cycle glitch on the minimum instance: rejected
    @(negedge clk); raw1 = 1'b1;
    @(negedge clk); raw1 = 1'b0;
    step1("mg_e2", 2'b00, 1'd0, 1'b0, 1'b0, 1'b0);
    step1("mg_e3", 2'b01, 1'd0, 1'b0, 1'b0, 1'b0);
    step1("mg_e4", 2'b00, 1'd0, 1'b0, 1'b0, 1'b0);
    step1("mg_e5", 2'b00, 1'd0, 1'b0, 1'b0, 1'b0);
    chk0("u0_quiet", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: consecutive matching samples, after the first, needed to accept a level change; legal range >= 1.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 3: width of the stability counter; 2**CNT_WIDTH >= STABLE_CYCLES.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port raw_in, input, 1 bit: raw switch/button level, asynchronous to clk.
REQ-006 Port clean_out, output, 1 bit: debounced level; drives the downstream sequence counter's input1.
REQ-007 Port rise, output, 1 bit: one-cycle pulse when clean_out goes 0->1.
REQ-008 Port fall, output, 1 bit: one-cycle pulse when clean_out goes 1->0.
REQ-009 Port state, output, 2 bits: current FSM state, for debug.
REQ-010 Port stable_cnt, output, CNT_WIDTH bits: current stability counter value.

Function
REQ-011 raw_in SHALL pass through a two-flop synchronizer; sync_in is the second-flop output; no logic SHALL read raw_in directly.
REQ-012 FSM encoding SHALL be: S_LOW=00, S_WAIT_HIGH=01, S_HIGH=10, S_WAIT_LOW=11.
REQ-013 S_LOW: if sync_in=1, go to S_WAIT_HIGH with cnt=0; otherwise stay, cnt=0.
REQ-014 S_WAIT_HIGH: if sync_in=0, go to S_LOW with cnt=0 (glitch rejected, no pulse).
REQ-015 S_WAIT_HIGH: if sync_in=1 and cnt==STABLE_CYCLES-1, go to S_HIGH with cnt=0 and assert rise on the next cycle.
REQ-016 S_WAIT_HIGH: otherwise cnt SHALL increment by 1.
REQ-017 S_HIGH and S_WAIT_LOW SHALL mirror S_LOW and S_WAIT_HIGH, with sync_in polarity inverted and fall in place of rise.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-019 clean_out SHALL be 1 exactly when state is S_HIGH or S_WAIT_LOW, decoded from registered state only.
REQ-020 rise and fall SHALL be registered, high for exactly one cycle per accepted transition, and never high simultaneously.
REQ-021 A level change SHALL be accepted only if sync_in holds the new level for STABLE_CYCLES+1 consecutive rising edges.
REQ-022 Acceptance latency: clean_out SHALL change after the (STABLE_CYCLES+3)th rising edge following a stable raw_in change; this is 7 edges at the default.
REQ-023 rise/fall SHALL assert in the same cycle that clean_out first shows the new level.
REQ-024 A return to the current level during S_WAIT_* SHALL abort the change; a subsequent change SHALL restart counting from cnt=0.

Reset
REQ-025 reset=0 SHALL immediately and asynchronously force: both synchronizer flops 0, state=S_LOW, cnt=0, clean_out=0, rise=0, fall=0.
REQ-026 Reset asserted mid-S_WAIT_* or in S_HIGH SHALL discard progress; no rise or fall pulse SHALL be generated by reset.
REQ-027 After reset release with raw_in=1, the block SHALL apply the full REQ-022 latency, then pulse rise.

Verification
REQ-028 Reset scenario: assert reset=0 at arbitrary times -> state=00, stable_cnt=0, clean_out=0, rise=0, fall=0, all asynchronously (clk period 20 ns).
REQ-029 Accept-rise scenario: raw_in 0->1 at a negedge, held -> state 00,00,00,01,01,01,01,10; clean_out=1 and rise=1 for one cycle after posedge 7.
REQ-030 Glitch scenario: raw_in high for exactly 4 cycles, then low -> no rise, clean_out stays 0, state returns to 00; the same test with 5 cycles -> accepted.
REQ-031 Accept-fall scenario: from S_HIGH, raw_in 1->0 held -> fall pulse and clean_out=0 after posedge 7; rise stays 0.
REQ-032 Reset mid-wait scenario: reset=0 while state=01, stable_cnt=2 -> immediate 00/0; release with raw_in=1 -> rise after a further 7 posedges.
REQ-033 Minimum-parameter scenario: instance with STABLE_CYCLES=1 -> clean_out follows a held raw_in change after posedge 4, and a 1-cycle glitch is rejected.
